eth_phy_10g_rx_bitslip_aligner: RTL and testbench
=================================================

Name: eth_phy_10g_rx_bitslip_aligner

Overview:
- RX-side alignment stage directly upstream of the 10GBASE-R RX PHY. It converts the unaligned 66-bit words from the SERDES into serdes_rx_data/serdes_rx_hdr.
- It applies the one-bit slips requested by the frame-sync block's serdes_rx_bitslip output.
- It replaces the ideal SERDES model, so block-lock acquisition can be exercised against a real bit offset.

Parameters:
- DATA_WIDTH, 64, payload width per block.
- HDR_WIDTH, 2, sync header width. Raw word width is W = DATA_WIDTH+HDR_WIDTH = 66.
- SLIP_HOLDOFF, 8, number of rx_clk cycles after an accepted slip during which further slip requests are ignored.

Ports:
- rx_clk  in  1  sole clock.
- rx_rst  in  1  synchronous, active-low reset.
- raw_rx_data  in  W  unaligned SERDES word; bit 0 is received first.
- raw_rx_valid  in  1  raw_rx_data is valid this cycle.
- serdes_rx_bitslip  in  1  slip request from frame sync; level, edge-detected here.
- serdes_rx_data  out  DATA_WIDTH  aligned payload.
- serdes_rx_hdr  out  HDR_WIDTH  aligned sync header.
- serdes_rx_valid  out  1  aligned word valid.
- slip_offset  out  7  current bit offset, 0..W-1.
- slip_busy  out  1  holdoff active.
- slip_wrap  out  1  one-cycle pulse when slip_offset wraps from W-1 to 0.

Behaviour:
- **Reset** (rx_rst==0 at a rising edge): all outputs are 0. The internal previous-word register is 0, the slip-edge register is 0, the holdoff counter is 0, and the FSM goes to EMPTY.
- **Window:** buf = {raw_rx_data, prev_word} (2W bits, prev_word in the low half); window = buf[slip_offset +: W].
- **Field mapping:** serdes_rx_hdr = window[HDR_WIDTH-1:0]; serdes_rx_data = window[W-1:HDR_WIDTH].
- **FSM states:**
  - EMPTY: on raw_rx_valid, prev_word <= raw_rx_data and go to RUN. No output.
  - RUN: on raw_rx_valid, register window into the outputs, set serdes_rx_valid=1, prev_word <= raw_rx_data.
- **Latency:**
  - The first output appears 1 cycle after the 2nd accepted raw word.
  - At offset 0, output = the previous raw word: 1 cycle after word N+1 is accepted, word N appears.
- **Valid gaps:** raw_rx_valid=0 in RUN gives serdes_rx_valid=0 next cycle; data/hdr hold their last value; prev_word is unchanged.
- **Slip edge detect:** slip_req = serdes_rx_bitslip & ~bitslip_d, where bitslip_d is registered every cycle.
- **Accepted slip** (slip_req && !slip_busy):
  - slip_offset <= (slip_offset==W-1) ? 0 : slip_offset+1.
  - slip_wrap <= 1 only in the wrap case, 0 otherwise.
  - The holdoff counter loads SLIP_HOLDOFF.
  - slip_busy = (counter != 0). The counter decrements every cycle to 0, whatever raw_rx_valid is.
- **Ignored slip:** slip_req while slip_busy is ignored entirely; no offset change and no queuing.
- **Slip and valid in the same cycle:** the output registered on that edge uses the old offset. The new offset applies from the next accepted word.
- **Offset width:** slip_offset is 7 bits and never exceeds 65. A level held high on serdes_rx_bitslip produces exactly one slip.
- **Reset mid-operation:** everything is cleared and the FSM returns to EMPTY. Two new valid words are required before serdes_rx_valid rises again.
- **Rising edge right after reset:** a serdes_rx_bitslip rising edge on the first cycle after reset is accepted, since bitslip_d was reset to 0.

Test Plan:
1. Reset: hold rx_rst=0 for 3 cycles with random inputs.
   -> All outputs 0; serdes_rx_valid stays 0 through the 1st valid word and rises 1 cycle after the 2nd.
2. Passthrough: stream constant R = {64'h0123456789ABCDEF, 2'b01} at offset 0.
   -> serdes_rx_hdr=2'b01, serdes_rx_data=64'h0123456789ABCDEF every valid cycle.
3. Single slip: pulse serdes_rx_bitslip while streaming R.
   -> slip_offset=1, slip_busy high for 8 cycles.
   -> The next accepted word's output equals R rotated right by 1 ({R[0],R[65:1]}): hdr=2'b10, data=64'h8091A2B3C4D5E6F7.
4. Wrap: issue 66 slips, each separated by 10 cycles.
   -> slip_offset counts 1..65 then 0; slip_wrap pulses exactly once, on the 66th slip.
   -> Output returns to hdr=2'b01, data=64'h0123456789ABCDEF.
5. Holdoff and level:
   - Second rising edge 3 cycles after the first -> offset stays 1.
   - serdes_rx_bitslip held high for 20 cycles -> exactly one increment.
6. Gaps and reset:
   - raw_rx_valid toggling 1,0,1,0 -> serdes_rx_valid toggles accordingly and data holds in the gaps.
   - rx_rst=0 mid-stream at offset 5 -> slip_offset=0 and re-prime behaviour as in scenario 1.

Source files
------------

// File: rtl/eth_phy_10g_rx_bitslip_aligner.sv
// eth_phy_10g_rx_bitslip_aligner
//   Turns unaligned 66-bit SERDES words into aligned payload + sync header.
//   A one-bit slip is applied on each accepted rising edge of
//   serdes_rx_bitslip. After a slip, further requests are ignored for a
//   holdoff window.
// Ports:
//   rx_clk, rx_rst (sync, active low)
//   raw_rx_data/raw_rx_valid          : unaligned input word, bit 0 first
//   serdes_rx_bitslip                 : slip request level (edge-detected)
//   serdes_rx_data/hdr/valid          : aligned output word
//   slip_offset                       : current bit offset 0..W-1
//   slip_busy                         : holdoff active
//   slip_wrap                         : pulse when the offset wraps to 0
module eth_phy_10g_rx_bitslip_aligner #(
  parameter int DATA_WIDTH   = 64,
  parameter int HDR_WIDTH    = 2,
  parameter int SLIP_HOLDOFF = 8
) (
  input  logic                            rx_clk,
  input  logic                            rx_rst,
  input  logic [DATA_WIDTH+HDR_WIDTH-1:0] raw_rx_data,
  input  logic                            raw_rx_valid,
  input  logic                            serdes_rx_bitslip,
  output logic [DATA_WIDTH-1:0]           serdes_rx_data,
  output logic [HDR_WIDTH-1:0]            serdes_rx_hdr,
  output logic                            serdes_rx_valid,
  output logic [6:0]                      slip_offset,
  output logic                            slip_busy,
  output logic                            slip_wrap
);
  localparam int W  = DATA_WIDTH + HDR_WIDTH;
  localparam int HW = $clog2(SLIP_HOLDOFF + 1);

  typedef enum logic {EMPTY, RUN} state_t;

  state_t          state, state_nxt;
  logic            load_prev, load_out;
  logic [W-1:0]    prev_word;
  logic [2*W-1:0]  buf_w;
  logic [W-1:0]    window;
  logic [7:0]      off_ext;
  logic            bitslip_d, slip_req, slip_acc;
  logic [HW-1:0]   hold_cnt;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge rx_clk) begin
    if (!rx_rst) state <= EMPTY;
    else         state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    if (state == EMPTY && raw_rx_valid) state_nxt = RUN;
  end

  // ---------------- FSM: outputs ----------------
  // prev_word is captured on every valid word; the first word after reset
  // only primes it, since the window needs two words.
  always_comb begin
    load_prev = raw_rx_valid;
    load_out  = (state == RUN) && raw_rx_valid;
  end

  // ---------------- datapath ----------------
  // The newest word sits in the high half, so a larger offset pulls later
  // bits into the window. The offset is widened to fit the 2W-bit index range.
  assign buf_w   = {raw_rx_data, prev_word};
  assign off_ext = {1'b0, slip_offset};
  assign window  = buf_w[off_ext +: W];

  always_ff @(posedge rx_clk) begin
    if (!rx_rst) begin
      prev_word       <= '0;
      serdes_rx_data  <= '0;
      serdes_rx_hdr   <= '0;
      serdes_rx_valid <= 1'b0;
    end else begin
      serdes_rx_valid <= load_out;
      if (load_prev) prev_word <= raw_rx_data;
      if (load_out) begin
        serdes_rx_hdr  <= window[HDR_WIDTH-1:0];
        serdes_rx_data <= window[W-1:HDR_WIDTH];
      end
    end
  end

  // ---------------- slip control ----------------
  // The request is a level. Only its rising edge counts, and only outside
  // the holdoff window. Ignored edges are dropped, not queued.
  assign slip_req  = serdes_rx_bitslip & ~bitslip_d;
  assign slip_busy = (hold_cnt != '0);
  assign slip_acc  = slip_req & ~slip_busy;

  always_ff @(posedge rx_clk) begin
    if (!rx_rst) begin
      bitslip_d   <= 1'b0;
      hold_cnt    <= '0;
      slip_offset <= '0;
      slip_wrap   <= 1'b0;
    end else begin
      bitslip_d <= serdes_rx_bitslip;
      slip_wrap <= 1'b0;
      if (slip_acc) begin
        hold_cnt <= HW'(SLIP_HOLDOFF);
        if (slip_offset == 7'(W-1)) begin
          slip_offset <= '0;
          slip_wrap   <= 1'b1;
        end else begin
          slip_offset <= slip_offset + 7'd1;
        end
      end else if (slip_busy) begin
        hold_cnt <= hold_cnt - HW'(1);
      end
    end
  end
endmodule

// File: tb/tb_eth_phy_10g_rx_bitslip_aligner.sv
module tb_eth_phy_10g_rx_bitslip_aligner;
  logic        rx_clk = 1'b0;
  logic        rx_rst;
  logic [65:0] raw_rx_data;
  logic        raw_rx_valid;
  logic        serdes_rx_bitslip;
  logic [63:0] serdes_rx_data;
  logic [1:0]  serdes_rx_hdr;
  logic        serdes_rx_valid;
  logic [6:0]  slip_offset;
  logic        slip_busy;
  logic        slip_wrap;

  int checks = 0;
  int errors = 0;
  int wrap_cnt = 0;
  logic wrap_now;

  localparam logic [65:0] R = {64'h0123456789ABCDEF, 2'b01};
  localparam logic [65:0] X = {64'hFEDCBA9876543210, 2'b10};
  localparam logic [65:0] A = {64'hDEADBEEFCAFEF00D, 2'b10};
  localparam logic [65:0] J = {64'h5555AAAA5555AAAA, 2'b11};

  eth_phy_10g_rx_bitslip_aligner dut (
    .rx_clk(rx_clk), .rx_rst(rx_rst),
    .raw_rx_data(raw_rx_data), .raw_rx_valid(raw_rx_valid),
    .serdes_rx_bitslip(serdes_rx_bitslip),
    .serdes_rx_data(serdes_rx_data), .serdes_rx_hdr(serdes_rx_hdr),
    .serdes_rx_valid(serdes_rx_valid),
    .slip_offset(slip_offset), .slip_busy(slip_busy), .slip_wrap(slip_wrap)
  );

  always #5 rx_clk = ~rx_clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge rx_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bitslip pulse followed by quiet cycles that outlast the holdoff.
  task automatic slip_pulse();
    serdes_rx_bitslip = 1'b1;
    step();
    wrap_now = slip_wrap;
    if (slip_wrap) wrap_cnt++;
    serdes_rx_bitslip = 1'b0;
    repeat (9) begin
      step();
      if (slip_wrap) wrap_cnt++;
    end
  endtask

  initial begin
    // ---- 1. reset with random inputs ----
    rx_rst = 1'b0;
    repeat (3) begin
      raw_rx_data       = {$urandom, $urandom, 2'($urandom)};
      raw_rx_valid      = 1'($urandom);
      serdes_rx_bitslip = 1'($urandom);
      step();
    end
    check("rst_valid",  {65'd0, serdes_rx_valid}, 66'd0);
    check("rst_data",   {2'b0, serdes_rx_data}, 66'd0);
    check("rst_hdr",    {64'b0, serdes_rx_hdr}, 66'd0);
    check("rst_offset", {59'b0, slip_offset}, 66'd0);
    check("rst_busy",   {65'd0, slip_busy}, 66'd0);
    check("rst_wrap",   {65'd0, slip_wrap}, 66'd0);

    rx_rst = 1'b1; serdes_rx_bitslip = 1'b0;
    raw_rx_valid = 1'b1; raw_rx_data = X;
    step();
    check("prime_valid0", {65'd0, serdes_rx_valid}, 66'd0);
    raw_rx_data = R;
    step();
    check("prime_valid1", {65'd0, serdes_rx_valid}, 66'd1);
    check("prime_data",   {2'b0, serdes_rx_data}, {2'b0, 64'hFEDCBA9876543210});
    check("prime_hdr",    {64'b0, serdes_rx_hdr}, {64'b0, 2'b10});

    // ---- 2. passthrough at offset 0 ----
    step();
    check("pass_data", {2'b0, serdes_rx_data}, {2'b0, 64'h0123456789ABCDEF});
    check("pass_hdr",  {64'b0, serdes_rx_hdr}, {64'b0, 2'b01});

    // ---- 6a. valid gaps: prev_word must not update in a gap ----
    raw_rx_valid = 1'b0; raw_rx_data = J;
    step();
    check("gap1_valid", {65'd0, serdes_rx_valid}, 66'd0);
    check("gap1_hold",  {2'b0, serdes_rx_data}, {2'b0, 64'h0123456789ABCDEF});
    raw_rx_valid = 1'b1; raw_rx_data = A;
    step();
    check("gap2_valid", {65'd0, serdes_rx_valid}, 66'd1);
    check("gap2_data",  {2'b0, serdes_rx_data}, {2'b0, 64'h0123456789ABCDEF});
    raw_rx_valid = 1'b0; raw_rx_data = J;
    step();
    check("gap3_valid", {65'd0, serdes_rx_valid}, 66'd0);
    raw_rx_valid = 1'b1; raw_rx_data = R;
    step();
    check("gap4_data", {2'b0, serdes_rx_data}, {2'b0, 64'hDEADBEEFCAFEF00D});
    check("gap4_hdr",  {64'b0, serdes_rx_hdr}, {64'b0, 2'b10});
    step();  // prev_word = R again

    // ---- 3. single slip ----
    serdes_rx_bitslip = 1'b1;
    step();
    check("slip1_offset", {59'b0, slip_offset}, 66'd1);
    check("slip1_busy",   {65'd0, slip_busy}, 66'd1);
    check("slip1_wrap",   {65'd0, slip_wrap}, 66'd0);
    serdes_rx_bitslip = 1'b0;
    step();
    check("slip1_hdr",  {64'b0, serdes_rx_hdr}, {64'b0, 2'b10});
    check("slip1_data", {2'b0, serdes_rx_data}, {2'b0, 64'h8091A2B3C4D5E6F7});
    repeat (5) step();
    check("busy_c7", {65'd0, slip_busy}, 66'd1);
    step();
    check("busy_c8", {65'd0, slip_busy}, 66'd1);
    step();
    check("busy_done", {65'd0, slip_busy}, 66'd0);

    // ---- 4. wrap: 65 more slips go 2..65 then 0 ----
    wrap_cnt = 0;
    for (int i = 2; i <= 66; i++) begin
      slip_pulse();
      check($sformatf("wrap_off%0d", i), {59'b0, slip_offset}, 66'(i % 66));
    end
    check("wrap_count", 66'(wrap_cnt), 66'd1);
    check("wrap_last",  {65'd0, wrap_now}, 66'd1);
    check("wrap_data",  {2'b0, serdes_rx_data}, {2'b0, 64'h0123456789ABCDEF});
    check("wrap_hdr",   {64'b0, serdes_rx_hdr}, {64'b0, 2'b01});

    // ---- 5. holdoff and held level ----
    serdes_rx_bitslip = 1'b1; step();
    serdes_rx_bitslip = 1'b0; step(); step();
    serdes_rx_bitslip = 1'b1; step();
    check("holdoff_ignore", {59'b0, slip_offset}, 66'd1);
    serdes_rx_bitslip = 1'b0;
    repeat (10) step();
    check("holdoff_noqueue", {59'b0, slip_offset}, 66'd1);
    serdes_rx_bitslip = 1'b1;
    repeat (20) step();
    serdes_rx_bitslip = 1'b0;
    step();
    check("level_once", {59'b0, slip_offset}, 66'd2);
    repeat (3) slip_pulse();
    check("off5", {59'b0, slip_offset}, 66'd5);

    // ---- 6b. reset mid-stream ----
    rx_rst = 1'b0;
    step();
    check("mrst_offset", {59'b0, slip_offset}, 66'd0);
    check("mrst_valid",  {65'd0, serdes_rx_valid}, 66'd0);
    check("mrst_data",   {2'b0, serdes_rx_data}, 66'd0);
    rx_rst = 1'b1; raw_rx_data = A;
    step();
    check("mrst_prime0", {65'd0, serdes_rx_valid}, 66'd0);
    raw_rx_data = R;
    step();
    check("mrst_prime1", {65'd0, serdes_rx_valid}, 66'd1);
    check("mrst_data1",  {2'b0, serdes_rx_data}, {2'b0, 64'hDEADBEEFCAFEF00D});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
